// File: rtl/branch_predict_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared encodings for the ID-stage branch resolver.
//   br_type_e : branch kind carried on id_branch_i
//   state_e   : resolver FSM states
//   CTR_RESET : power-up value of every BHT counter (weakly not-taken)
//   taken()   : branch-outcome rule for a kind plus an rs==rt result
// ---------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JMP  = 2'b11
  } br_type_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [1:0] CTR_RESET = 2'b01;

  // beq follows the comparator, bne inverts it, an unconditional jump is
  // always taken, and "no branch" is never taken
  function automatic logic taken(input logic [1:0] br_type, input logic eq);
    case (br_type)
      BR_BEQ:  taken = eq;
      BR_BNE:  taken = !eq;
      BR_JMP:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// ---------------------------------------------------------------------------
// branch_predict_unit_if
// Bundles the pipeline-facing signals of branch_predict_unit.
//   master : pipeline side (drives ID/EX inputs, observes redirect/flush/stall)
//   slave  : the resolver itself
// Inputs : id_valid_i, id_branch_i, id_pc_i, id_target_i, id_ops_ready_i,
//          id_eq_i, res_valid_i, res_eq_i
// Outputs: pc_src_o, redirect_pc_o, flush_o, stall_o, pending_o,
//          stat_branches_o, stat_mispred_o
// ---------------------------------------------------------------------------
interface branch_predict_unit_if #(
  parameter int PC_W = 32
);

  logic            id_valid_i;
  logic [1:0]      id_branch_i;
  logic [PC_W-1:0] id_pc_i;
  logic [PC_W-1:0] id_target_i;
  logic            id_ops_ready_i;
  logic            id_eq_i;
  logic            res_valid_i;
  logic            res_eq_i;

  logic            pc_src_o;
  logic [PC_W-1:0] redirect_pc_o;
  logic            flush_o;
  logic            stall_o;
  logic            pending_o;
  logic [31:0]     stat_branches_o;
  logic [31:0]     stat_mispred_o;

  modport master (
    output id_valid_i, id_branch_i, id_pc_i, id_target_i, id_ops_ready_i,
           id_eq_i, res_valid_i, res_eq_i,
    input  pc_src_o, redirect_pc_o, flush_o, stall_o, pending_o,
           stat_branches_o, stat_mispred_o
  );

  modport slave (
    input  id_valid_i, id_branch_i, id_pc_i, id_target_i, id_ops_ready_i,
           id_eq_i, res_valid_i, res_eq_i,
    output pc_src_o, redirect_pc_o, flush_o, stall_o, pending_o,
           stat_branches_o, stat_mispred_o
  );

endinterface

// File: rtl/branch_predict_unit_bht.sv
// ---------------------------------------------------------------------------
// bht_counter_table
// Branch history table of saturating counters.
//   clk, rst_n        : clock, async active-low reset (all counters -> CTR_RESET)
//   rd_idx / rd_ctr   : combinational read port
//   wr_en, wr_idx,
//   wr_taken          : one saturating update per cycle (+1 taken, -1 not)
// A read of the entry being written returns the pre-update value because the
// read is taken straight from the registers.
// ---------------------------------------------------------------------------
module bht_counter_table
  import branch_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int CTR_W = 2,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(CTR_RESET);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

  logic [CTR_W-1:0] ctr_q [DEPTH];

  assign rd_ctr = ctr_q[rd_idx];

  // counters saturate at both ends so a long run in one direction cannot
  // wrap the prediction around
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
    end else if (wr_en) begin
      if (wr_taken) begin
        if (ctr_q[wr_idx] != CTR_MAX) ctr_q[wr_idx] <= ctr_q[wr_idx] + CTR_ONE;
      end else begin
        if (ctr_q[wr_idx] != '0) ctr_q[wr_idx] <= ctr_q[wr_idx] - CTR_ONE;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
// ID-stage branch resolver with a bimodal predictor.
//   clk, rst_n : clock, async active-low reset
//   bus        : branch_predict_unit_if.slave (ID inputs, EX late result,
//                PC redirect / flush / stall / pending, statistics)
// Branches with ready operands resolve in ID with zero latency; branches
// waiting on an EX result are predicted from the BHT and checked when
// res_valid_i arrives, flushing and redirecting on a mispredict.
// Optional feature macro: BRANCH_STATS_EN enables the saturating
// resolved-branch and mispredict counters; otherwise both read zero.
// ---------------------------------------------------------------------------
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter  int PC_W      = 32,
  parameter  int BHT_DEPTH = 64,
  parameter  int CTR_W     = 2,
  localparam int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predict_unit_if.slave bus
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx;
  logic [CTR_W-1:0] rd_ctr;
  logic             pred;
  logic             id_br;
  logic             id_cond;

  logic [IDX_W-1:0] pend_idx_q;
  logic             pend_pred_q;
  logic [1:0]       pend_type_q;
  logic [PC_W-1:0]  pend_target_q;
  logic [PC_W-1:0]  pend_pc4_q;

  logic             pc_src;
  logic [PC_W-1:0]  redirect;
  logic             flush;
  logic             stall;
  logic             capture;
  logic             resolve_cond;
  logic             actual;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_taken;

  assign idx     = bus.id_pc_i[IDX_W+1:2];
  assign pred    = rd_ctr[CTR_W-1];
  assign id_br   = bus.id_valid_i && (bus.id_branch_i != BR_NONE);
  assign id_cond = (bus.id_branch_i == BR_BEQ) || (bus.id_branch_i == BR_BNE);

  bht_counter_table #(
    .DEPTH (BHT_DEPTH),
    .CTR_W (CTR_W)
  ) u_bht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .rd_ctr   (rd_ctr),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_taken (wr_taken)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Snapshot of an unresolved branch; pc+4 is kept so a wrongly-taken
  // prediction can fall back to the sequential path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_idx_q    <= '0;
      pend_pred_q   <= 1'b0;
      pend_type_q   <= 2'b00;
      pend_target_q <= '0;
      pend_pc4_q    <= '0;
    end else if (capture) begin
      pend_idx_q    <= idx;
      pend_pred_q   <= pred;
      pend_type_q   <= bus.id_branch_i;
      pend_target_q <= bus.id_target_i;
      pend_pc4_q    <= bus.id_pc_i + PC_W'(4);
    end
  end

  // Next-state and output decode. While a branch is pending no new ID branch
  // is accepted, so the BHT sees at most one write per cycle.
  always_comb begin
    state_d      = state_q;
    pc_src       = 1'b0;
    redirect     = '0;
    flush        = 1'b0;
    stall        = 1'b0;
    capture      = 1'b0;
    resolve_cond = 1'b0;
    actual       = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = idx;
    wr_taken     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (id_br) begin
          redirect = bus.id_target_i;
          if (!id_cond) begin
            pc_src = 1'b1;
          end else if (bus.id_ops_ready_i) begin
            actual       = taken(bus.id_branch_i, bus.id_eq_i);
            pc_src       = actual;
            wr_en        = 1'b1;
            wr_idx       = idx;
            wr_taken     = actual;
            resolve_cond = 1'b1;
          end else begin
            pc_src  = pred;
            capture = 1'b1;
            state_d = ST_PENDING;
          end
        end
      end
      ST_PENDING: begin
        stall = id_br;
        if (bus.res_valid_i) begin
          actual       = taken(pend_type_q, bus.res_eq_i);
          wr_en        = 1'b1;
          wr_idx       = pend_idx_q;
          wr_taken     = actual;
          resolve_cond = 1'b1;
          state_d      = ST_IDLE;
          if (actual != pend_pred_q) begin
            flush    = 1'b1;
            pc_src   = 1'b1;
            redirect = actual ? pend_target_q : pend_pc4_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so nothing downstream acts on
  // a half-initialised resolver
  assign bus.pc_src_o      = rst_n && pc_src;
  assign bus.redirect_pc_o = rst_n ? redirect : '0;
  assign bus.flush_o       = rst_n && flush;
  assign bus.stall_o       = rst_n && stall;
  assign bus.pending_o     = rst_n && (state_q == ST_PENDING);

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mis_q;

  // Saturating statistics: every conditional resolution and every flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (resolve_cond && (stat_br_q != 32'hFFFF_FFFF)) stat_br_q <= stat_br_q + 32'd1;
      if (flush && (stat_mis_q != 32'hFFFF_FFFF)) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign bus.stat_branches_o = stat_br_q;
  assign bus.stat_mispred_o  = stat_mis_q;
`else
  logic unused_stats;
  assign unused_stats        = resolve_cond;
  assign bus.stat_branches_o = 32'h0;
  assign bus.stat_mispred_o  = 32'h0;
`endif

  logic unused_bits;
  assign unused_bits = ^{bus.id_pc_i[PC_W-1:IDX_W+2], bus.id_pc_i[1:0], rd_ctr[CTR_W-2:0]};

endmodule
